// File: rtl/exec_sequencer.sv
// exec_sequencer: fixed-schedule instruction sequencer (RD_A, RD_B, EXEC, WB) over a shared
// register memory and ALU. Optional macro SEQ_SAME_ADDR_SKIP_EN skips RD_B when addr1 == addr2.
module exec_sequencer #(
  parameter logic [15:0] WB_MASK = 16'h3FFF,
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [3:0]        ins_opcode,
  input  logic [ADDR_W-1:0] ins_addr1,
  input  logic [ADDR_W-1:0] ins_addr2,
  input  logic [ADDR_W-1:0] ins_addr3,
  input  logic [DATA_W-1:0] ins_load_number,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_load_number,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flag,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flag,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
`ifdef SEQ_SAME_ADDR_SKIP_EN
  logic              same_addr;
`endif

  // Sequencer FSM; mem_addr is loaded one state early so every output is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr2           <= '0;
      addr3           <= '0;
`ifdef SEQ_SAME_ADDR_SKIP_EN
      same_addr       <= 1'b0;
`endif
      ins_ready       <= 1'b0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      alu_opcode      <= 4'd0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_load_number <= '0;
      result          <= '0;
      flag            <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          done   <= 1'b0;
          if (ins_valid && ins_ready) begin
            alu_opcode      <= ins_opcode;
            alu_load_number <= ins_load_number;
            addr2           <= ins_addr2;
            addr3           <= ins_addr3;
`ifdef SEQ_SAME_ADDR_SKIP_EN
            same_addr       <= (ins_addr1 == ins_addr2);
`endif
            mem_addr        <= ins_addr1;
            ins_ready       <= 1'b0;
            busy            <= 1'b1;
            state           <= RD_A;
          end else begin
            ins_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        RD_A: begin
          alu_a <= mem_rdata;
`ifdef SEQ_SAME_ADDR_SKIP_EN
          if (same_addr) begin
            alu_b <= mem_rdata;
            state <= EXEC;
          end else begin
            mem_addr <= addr2;
            state    <= RD_B;
          end
`else
          mem_addr <= addr2;
          state    <= RD_B;
`endif
        end
        RD_B: begin
          alu_b <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          // Write data is taken from alu_out directly so it equals result during WB.
          result    <= alu_out;
          flag      <= alu_flag;
          mem_addr  <= addr3;
          mem_wdata <= alu_out;
          mem_we    <= WB_MASK[alu_opcode];
          done      <= 1'b1;
          state     <= WB;
        end
        WB: begin
          mem_we    <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          ins_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_we    <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          ins_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer with a behavioural 32x8 memory and small ALU.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ins_valid;
  logic       ins_ready;
  logic [3:0] ins_opcode;
  logic [4:0] ins_addr1, ins_addr2, ins_addr3;
  logic [7:0] ins_load_number;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_load_number;
  logic [7:0] alu_out;
  logic [3:0] alu_flag;
  logic [7:0] result;
  logic [3:0] flag;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_opcode(ins_opcode),
    .ins_addr1(ins_addr1), .ins_addr2(ins_addr2), .ins_addr3(ins_addr3),
    .ins_load_number(ins_load_number),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_load_number(alu_load_number),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .result(result), .flag(flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: bench preload port plus DUT write port, combinational read.
  logic [7:0] mem [0:31];
  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = 5'd0;
  logic [7:0] pre_data = 8'h00;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  // ALU model: op0 add, op14 subtract, others pass the immediate.
  logic [8:0] wide;
  always_comb begin
    case (alu_opcode)
      4'd0:    wide = {1'b0, alu_a} + {1'b0, alu_b};
      4'd14:   wide = {1'b0, alu_a} - {1'b0, alu_b};
      default: wide = {1'b0, alu_load_number};
    endcase
    alu_out  = wide[7:0];
    alu_flag = {wide[8], (wide[7:0] == 8'h00), (alu_a > alu_b), (alu_a == alu_b)};
  end

  // Event counters: cycles, accepted instructions, write strobes.
  int cyc = 0, accept_cnt = 0, acc_cyc = 0, we_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ins_valid && ins_ready) begin
      accept_cnt <= accept_cnt + 1;
      acc_cyc    <= cyc;
    end
    if (mem_we) we_count <= we_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, ins_ready, 0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_we"},    mem_we, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_op"},    alu_opcode, 0);
    check({tag, "_a"},     alu_a, 0);
    check({tag, "_b"},     alu_b, 0);
    check({tag, "_imm"},   alu_load_number, 0);
    check({tag, "_res"},   result, 0);
    check({tag, "_flag"},  flag, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3, input logic [7:0] imm,
                           input logic [7:0] exp_res, input logic [3:0] exp_flag,
                           input logic exp_we, input int exp_lat);
    logic [7:0] va, vb, old3;
    int w, lat, we_base;
    va = mem[a1]; vb = mem[a2]; old3 = mem[a3];
    w = 0;
    while (!ins_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, "_ready"}, ins_ready, 1);
    ins_valid = 1'b1; ins_opcode = op; ins_addr1 = a1; ins_addr2 = a2; ins_addr3 = a3;
    ins_load_number = imm;
    we_base = we_count;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    lat = 1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_low"}, ins_ready, 0);
    check({tag, "_aluop"}, alu_opcode, op);
    check({tag, "_aluimm"}, alu_load_number, imm);
    check({tag, "_rda_addr"}, mem_addr, a1);
    while (!done && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        check({tag, "_alu_a"}, alu_a, va);
        if (exp_lat == 4) check({tag, "_rdb_addr"}, mem_addr, a2);
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_alu_b"}, alu_b, vb);
    check({tag, "_wb_addr"}, mem_addr, a3);
    check({tag, "_wb_we"}, mem_we, exp_we);
    check({tag, "_wb_wdata"}, mem_wdata, exp_res);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flag"}, flag, exp_flag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_we_off"}, mem_we, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_ready"}, ins_ready, 1);
    check({tag, "_we_cycles"}, we_count - we_base, {31'd0, exp_we});
    check({tag, "_mem"}, mem[a3], exp_we ? exp_res : old3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t1, lat, k, we_base;
    rst_n = 1'b0; ins_valid = 1'b0; ins_opcode = 4'd0;
    ins_addr1 = 5'd0; ins_addr2 = 5'd0; ins_addr3 = 5'd0; ins_load_number = 8'h00;
    #1;
    check_zero("reset");
    poke(5'd3, 8'h12);  poke(5'd4, 8'h34);  poke(5'd6, 8'hA5); poke(5'd9, 8'h05);
    poke(5'd20, 8'h11); poke(5'd21, 8'h22); poke(5'd22, 8'h5C);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", ins_ready, 0);
    @(posedge clk);
    #1;
    check("rel_ready_high", ins_ready, 1);
    @(negedge clk);

    run_instr("add",   4'd0,  5'd3, 5'd4, 5'd5, 8'h00, 8'h46, 4'b0000, 1'b1, 4);
    run_instr("flags", 4'd14, 5'd3, 5'd4, 5'd6, 8'h00, 8'hDE, 4'b1000, 1'b0, 4);

    // Back-to-back with ins_valid held high: hazard through mem[3].
    ins_valid = 1'b1; ins_opcode = 4'd0; ins_addr1 = 5'd3; ins_addr2 = 5'd4; ins_addr3 = 5'd3;
    ins_load_number = 8'h00;
    base = accept_cnt;
    @(posedge clk);
    @(negedge clk);
    check("hz_acc1", accept_cnt - base, 1);
    t1 = acc_cyc;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        check("hz_ready_busy", ins_ready, 0);
        check("hz_no_reaccept", accept_cnt - base, 1);
      end
    end
    check("hz_lat1", lat, 4);
    check("hz_wdata1", mem_wdata, 8'h46);
    ins_addr3 = 5'd7;
    k = 0;
    while ((accept_cnt - base) < 2 && k < 10) begin @(posedge clk); @(negedge clk); k++; end
    ins_valid = 1'b0;
    check("hz_acc2", accept_cnt - base, 2);
    check("hz_gap", acc_cyc - t1, 5);
    lat = 1;
    while (!done && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
    check("hz_lat2", lat, 4);
    check("hz_result2", result, 8'h7A);
    check("hz_flag2", flag, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    check("hz_mem3", mem[3], 8'h46);
    check("hz_mem7", mem[7], 8'h7A);
    check("hz_acc_total", accept_cnt - base, 2);

    // Reset asserted while in RD_B.
    ins_valid = 1'b1; ins_opcode = 4'd0; ins_addr1 = 5'd20; ins_addr2 = 5'd21; ins_addr3 = 5'd22;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_alu_a", alu_a, 8'h11);
    check("mid_rdb_addr", mem_addr, 5'd21);
    we_base = we_count;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_write", we_count - we_base, 0);
    check("midrst_mem22", mem[22], 8'h5C);

`ifdef SEQ_SAME_ADDR_SKIP_EN
    run_instr("same", 4'd0, 5'd9, 5'd9, 5'd10, 8'h00, 8'h0A, 4'b0001, 1'b1, 3);
`else
    run_instr("same", 4'd0, 5'd9, 5'd9, 5'd10, 8'h00, 8'h0A, 4'b0001, 1'b1, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
